// File: rtl/sha3_padder.sv
// sha3_padder: packs a byte stream into SHA-3 rate blocks
// and applies pad10*1 with a domain-separation suffix.
module sha3_padder #(
  parameter int D = 256,
  parameter logic [7:0] SUFFIX = 8'h06,
  localparam int R = 1600 - 2 * D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic [R-1:0] block,
  output logic         block_valid,
  output logic         block_last,
  input  logic         block_ready
);

  localparam int NB = R / 8;
  localparam int CW = $clog2(NB);
  localparam int PW = CW + 3;

  typedef enum logic {FILL, OUT} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [R-1:0]   buffer, buf_n;
  logic           pad_pending, pad_n;
  logic           last_r, last_n;
  logic [PW-1:0]  pos, pos1;
  logic           at_end;

  assign pos    = {cnt, 3'b000};
  assign pos1   = pos + PW'(8);
  assign at_end = (cnt == CW'(NB - 1));

  assign in_ready    = (state == FILL) && reset;
  assign block_valid = (state == OUT);
  assign block_last  = last_r;
  assign block       = buffer;

  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FILL;
      cnt         <= '0;
      buffer      <= '0;
      pad_pending <= 1'b0;
      last_r      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      buffer      <= buf_n;
      pad_pending <= pad_n;
      last_r      <= last_n;
    end
  end

  // next-state: byte packing, padding and block handoff
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    buf_n   = buffer;
    pad_n   = pad_pending;
    last_n  = last_r;
    unique case (state)
      FILL: begin
        if (in_valid) begin
          if (!in_last) begin
            buf_n[pos +: 8] = in_data;
            if (at_end) begin
              state_n = OUT;
              last_n  = 1'b0;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else if (in_empty) begin
            buf_n[pos +: 8]   = SUFFIX;
            buf_n[R-1 -: 8]   = buf_n[R-1 -: 8] | 8'h80;
            state_n = OUT;
            last_n  = 1'b1;
          end else if (at_end) begin
            // suffix does not fit; a pad-only block follows
            buf_n[pos +: 8] = in_data;
            state_n = OUT;
            last_n  = 1'b0;
            pad_n   = 1'b1;
          end else begin
            buf_n[pos +: 8]  = in_data;
            buf_n[pos1 +: 8] = SUFFIX;
            buf_n[R-1 -: 8]  = buf_n[R-1 -: 8] | 8'h80;
            state_n = OUT;
            last_n  = 1'b1;
          end
        end
      end
      OUT: begin
        if (block_ready) begin
          buf_n = '0;
          if (pad_pending) begin
            buf_n[7:0]      = SUFFIX;
            buf_n[R-1 -: 8] = 8'h80;
            last_n = 1'b1;
            pad_n  = 1'b0;
          end else begin
            cnt_n   = '0;
            state_n = FILL;
            last_n  = 1'b0;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sha3_padder.sv
// tb_sha3_padder: directed and random message checks
// against a queue-based pad10*1 reference model.
module tb_sha3_padder;

  localparam int D  = 256;
  localparam int R  = 1600 - 2 * D;
  localparam int NB = R / 8;
  localparam logic [7:0] SUFFIX = 8'h06;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [R-1:0] block;
  logic         block_valid;
  logic         block_last;
  logic         block_ready;

  int n_chk = 0;
  int n_fail = 0;
  int rdy_mode = 0;

  logic [7:0]   bd[$];
  logic         bl[$];
  logic         be[$];
  logic [R-1:0] eb[$];
  logic         el[$];
  logic [7:0]   msg[$];

  sha3_padder #(.D(D), .SUFFIX(SUFFIX)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_empty(in_empty),
    .in_ready(in_ready),
    .block(block),
    .block_valid(block_valid),
    .block_last(block_last),
    .block_ready(block_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [R-1:0] obs,
                         input logic [R-1:0] exp);
    int idx;
    idx = 0;
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      for (int i = 0; i < NB; i++)
        if (obs[8*i +: 8] !== exp[8*i +: 8]) begin
          idx = i;
          break;
        end
      $error("FAIL %s byte %0d observed %h expected %h",
             tag, idx, obs[8*idx +: 8], exp[8*idx +: 8]);
    end
  endtask

  // model: append suffix, zero-fill to a block multiple, set final bit
  task automatic queue_msg(input bit use_empty);
    logic [7:0] p[$];
    logic [R-1:0] v;
    int nblk;
    p = msg;
    p.push_back(SUFFIX);
    while (p.size() % NB != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / NB;
    for (int b = 0; b < nblk; b++) begin
      v = '0;
      for (int i = 0; i < NB; i++) v[8*i +: 8] = p[b*NB + i];
      eb.push_back(v);
      el.push_back(b == nblk - 1);
    end
    for (int i = 0; i < msg.size(); i++) begin
      bd.push_back(msg[i]);
      if (i == msg.size() - 1) begin
        bl.push_back(!use_empty);
        be.push_back(use_empty ? ($urandom % 2 == 0) : 1'b0);
      end else begin
        bl.push_back(1'b0);
        be.push_back($urandom % 4 == 0);
      end
    end
    if (use_empty || msg.size() == 0) begin
      bd.push_back(8'($urandom));
      bl.push_back(1'b1);
      be.push_back(1'b1);
    end
  endtask

  task automatic drive();
    if (bd.size() > 0) begin
      in_valid = 1'b1;
      in_data  = bd[0];
      in_last  = bl[0];
      in_empty = be[0];
    end else begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'b0;
      in_empty = 1'b0;
    end
  endtask

  task automatic run(input int budget, input bit stop_on_valid);
    int cyc;
    bit done;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < budget) begin
      if (bd.size() == 0 && eb.size() == 0 && !block_valid)
        done = 1'b1;
      else if (stop_on_valid && block_valid)
        done = 1'b1;
      else begin
        drive();
        case (rdy_mode)
          0: block_ready = 1'b1;
          1: block_ready = 1'($urandom % 2);
          default: block_ready = 1'b0;
        endcase
        #1;
        if (block_valid) chk("out_in_ready", in_ready, 0);
        else chk("idle_last", block_last, 0);
        if (block_valid && block_ready) begin
          chk("blk_expected", eb.size() > 0, 1);
          if (eb.size() > 0) begin
            chk_blk("block", block, eb[0]);
            chk("block_last", block_last, el[0]);
            void'(eb.pop_front());
            void'(el.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          void'(bd.pop_front());
          void'(bl.pop_front());
          void'(be.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    chk("run_done", done, 1);
  endtask

  task automatic rand_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  initial begin
    int len;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    in_empty = 1'b0;
    block_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk_blk("rst_block", block, '0);
    chk("rst_valid", block_valid, 0);
    chk("rst_last", block_last, 0);
    chk("rst_in_ready2", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // zero-length message and one-cycle latency
    msg.delete();
    queue_msg(1'b1);
    bd.delete(); bl.delete(); be.delete();
    in_valid = 1'b1;
    in_last = 1'b1;
    in_empty = 1'b1;
    in_data = 8'h55;
    block_ready = 1'b0;
    #1;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_valid_pre", block_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t1_valid_lat", block_valid, 1);
    rdy_mode = 0;
    run(20, 1'b0);

    // single byte A5
    msg.delete();
    msg.push_back(8'hA5);
    queue_msg(1'b0);
    run(20, 1'b0);

    // 135 bytes: pad byte lands at NB-1
    msg.delete();
    for (int i = 0; i < NB - 1; i++) msg.push_back(8'(i));
    queue_msg(1'b0);
    rdy_mode = 1;
    run(400, 1'b0);

    // 136 bytes: trailing pad-only block
    rand_msg(NB);
    queue_msg(1'b0);
    run(400, 1'b0);

    // backpressure: hold 5 cycles, next message pending
    rand_msg(10);
    queue_msg(1'b0);
    rand_msg(5);
    queue_msg(1'b0);
    rdy_mode = 2;
    run(100, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive();
      block_ready = 1'b0;
      #1;
      chk_blk("bp_block", block, eb[0]);
      chk("bp_last", block_last, el[0]);
      chk("bp_valid", block_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    drive();
    block_ready = 1'b1;
    #1;
    chk_blk("bp_hs_block", block, eb[0]);
    void'(eb.pop_front());
    void'(el.pop_front());
    @(posedge clk);
    #1;
    chk("bp_fill_valid", block_valid, 0);
    chk("bp_fill_ready", in_ready, 1);
    rdy_mode = 1;
    run(200, 1'b0);

    // reset after 50 bytes discards partial data
    msg.delete();
    for (int i = 0; i < 50; i++) begin
      bd.push_back(8'($urandom) | 8'h01);
      bl.push_back(1'b0);
      be.push_back(1'b0);
    end
    rdy_mode = 0;
    run(200, 1'b0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk_blk("mid_rst_block", block, '0);
    chk("mid_rst_valid", block_valid, 0);
    reset = 1'b1;
    msg.delete();
    msg.push_back(8'h3C);
    queue_msg(1'b0);
    run(20, 1'b0);

    // random back-to-back messages
    for (int m = 0; m < 12; m++) begin
      case ($urandom % 4)
        0: len = NB * ($urandom_range(1, 2)) - $urandom_range(0, 1);
        default: len = $urandom_range(0, 300);
      endcase
      rand_msg(len);
      queue_msg(1'($urandom % 2));
    end
    rdy_mode = 1;
    run(20000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
